abro_multi_event_fsm: RTL and testbench
=======================================

// Module: abro_multi_event_fsm
// PURPOSE
//  Generalised ABRO controller: waits for every enabled event of N_EVENTS inputs, in any
//  order or simultaneously, then asserts o; re-arms only on restart r_in. Adds an
//  optional collection timeout window, pulse/level output mode and a completion counter.
//  Sits between input-event conditioning and the control/status logic that consumes o.
// PARAMETERS
//  N_EVENTS      4   number of event inputs (>=2)
//  WINDOW_CYCLES 0   max cycles from first accepted event to completion; 0 = no timeout
//  OUT_MODE      0   0 = o is 1-cycle pulse; 1 = o held high until r_in/reset
//  COUNT_W       8   width of fire_count
// PORTS
//  clk          in   1         clock; all logic on rising edge
//  reset        in   1         synchronous, active-high reset
//  ev_in        in   N_EVENTS  event strobes, sampled every cycle
//  ev_mask      in   N_EVENTS  1 = event required; 0 = ignored
//  r_in         in   1         restart: clear progress, return to IDLE
//  o            out  1         completion output (see OUT_MODE)
//  seen         out  N_EVENTS  events accepted in current round
//  state        out  2         00 IDLE, 01 COLLECT, 10 DONE
//  timeout      out  1         1-cycle pulse when window expires
//  fire_count   out  COUNT_W   completions since reset, saturating
// BEHAVIOUR
//  Reset: state=IDLE, seen=0, o=0, timeout=0, fire_count=0, window counter=0.
//  Priority per cycle: reset > r_in > timeout expiry > event accept.
//  acc = ev_in & ev_mask; seen_nx = seen | acc; complete = (seen_nx & ev_mask)==ev_mask.
//  IDLE: acc==0 -> stay. acc!=0 & complete -> DONE. acc!=0 & !complete -> COLLECT, seen=acc.
//  COLLECT: seen<=seen_nx; complete -> DONE. Repeated event already in seen: no effect.
//  DONE: events ignored, seen frozen; r_in -> IDLE, seen=0. Without r_in stays indefinitely.
//  o latency: o high in the cycle after the completing event is sampled (registered).
//   OUT_MODE 0: o high exactly 1 cycle; OUT_MODE 1: o high while state==DONE.
//  fire_count increments on each IDLE/COLLECT->DONE transition; holds at 2^COUNT_W-1.
//  Window (WINDOW_CYCLES>0): counter loads on IDLE->COLLECT, increments each COLLECT cycle;
//   expires in the cycle where the count reaches WINDOW_CYCLES without completion:
//   timeout=1 next cycle, seen=0, state=IDLE; events in the expiry cycle are discarded.
//   Completion in the expiry cycle wins over timeout (-> DONE, no timeout pulse).
//  r_in with events same cycle: events discarded, next state IDLE, o=0 next cycle.
//  r_in in IDLE/COLLECT: clears seen and window; no o, no timeout.
//  ev_mask==0: never completes, stays IDLE. Mask may change any cycle; completion is
//   judged against current mask, so clearing the last outstanding bit completes the round.
//  Bits of seen outside ev_mask are retained but not required.
//  Reset mid-round: all state cleared next cycle regardless of OUT_MODE.
// STRUCTURE
//  Package abro_pkg: state typedef/localparams (ST_IDLE, ST_COLLECT, ST_DONE),
//   OUT_PULSE/OUT_LEVEL constants.
//  Sub-module abro_window_timer: load/enable/expire counter, width $clog2(WINDOW_CYCLES+1);
//   not instantiated when WINDOW_CYCLES==0.
//  Top: seen register, next-state logic, output register, saturating fire_count.
// TESTING (N_EVENTS=4, COUNT_W=8 unless noted)
//  1 mask=1111, ev 0001,0100,0010,1000 on cycles 1-4 -> state 01 from cyc2, o=1 in cyc5
//    only (mode 0), fire_count=1, no second o while idle in DONE.
//  2 mask=1111, ev=1111 in one cycle -> IDLE->DONE directly, o=1 next cycle; OUT_MODE 1:
//    o stays high 20 cycles until r_in, then o=0, state=00, seen=0.
//  3 WINDOW_CYCLES=5, ev 0001 then nothing -> timeout pulse after window, seen=0, state=00;
//    completion on expiry cycle -> o=1, timeout=0.
//  4 r_in together with completing event -> o never asserts, state=00, fire_count unchanged.
//  5 mask=1111, seen=0111, drop mask bit3 -> DONE, o=1; mask=0000 with random ev -> stays IDLE.
//  6 COUNT_W=2, five rounds -> fire_count 1,2,3,3,3; reset mid-COLLECT -> all outputs 0.

Source files
------------

// File: rtl/abro_pkg.sv
// Shared types and constants for the multi-event ABRO controller.
// State encoding matches the externally visible state port.
package abro_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_COLLECT = 2'b01,
    ST_DONE    = 2'b10
  } state_t;

  localparam int unsigned OUT_PULSE = 0;
  localparam int unsigned OUT_LEVEL = 1;

endpackage

// File: rtl/abro_window_timer.sv
// Collection window counter for the ABRO controller.
// Flags expiry in the collect cycle where the count reaches the window.
module abro_window_timer #(
  parameter int unsigned WINDOW_CYCLES = 5
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic en,
  output logic expire
);

  localparam int CW = $clog2(WINDOW_CYCLES + 1);

  logic [CW-1:0] cnt;

  assign expire = en && (cnt == CW'(WINDOW_CYCLES - 1));

  // Restart on load, otherwise count collect cycles.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/abro_multi_event_fsm.sv
// Generalised ABRO: fire once every enabled event has been seen,
// re-arm on restart, with optional window timeout and fire counter.
module abro_multi_event_fsm
  import abro_pkg::*;
#(
  parameter int unsigned N_EVENTS      = 4,
  parameter int unsigned WINDOW_CYCLES = 0,
  parameter int unsigned OUT_MODE      = 0,
  parameter int unsigned COUNT_W       = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [N_EVENTS-1:0] ev_in,
  input  logic [N_EVENTS-1:0] ev_mask,
  input  logic                r_in,
  output logic                o,
  output logic [N_EVENTS-1:0] seen,
  output logic [1:0]          state,
  output logic                timeout,
  output logic [COUNT_W-1:0]  fire_count
);

  state_t              st;
  logic [N_EVENTS-1:0] acc;
  logic [N_EVENTS-1:0] seen_nx;
  logic                complete;
  logic                expire;

  assign acc      = ev_in & ev_mask;
  assign seen_nx  = seen | acc;
  assign complete = ((seen_nx & ev_mask) == ev_mask);
  assign state    = st;

  if (WINDOW_CYCLES > 0) begin : g_win
    logic load;
    logic en;
    assign load = r_in
                | ((st == ST_IDLE) && (|acc) && !complete);
    assign en   = !r_in && (st == ST_COLLECT);
    abro_window_timer #(
      .WINDOW_CYCLES(WINDOW_CYCLES)
    ) u_timer (
      .clk   (clk),
      .reset (reset),
      .load  (load),
      .en    (en),
      .expire(expire)
    );
  end else begin : g_nowin
    assign expire = 1'b0;
  end

  // Round control, registered outputs and saturating fire counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      st         <= ST_IDLE;
      seen       <= '0;
      o          <= 1'b0;
      timeout    <= 1'b0;
      fire_count <= '0;
    end else begin
      timeout <= 1'b0;
      if (OUT_MODE == OUT_PULSE) o <= 1'b0;
      if (r_in) begin
        st   <= ST_IDLE;
        seen <= '0;
        o    <= 1'b0;
      end else begin
        unique case (st)
          ST_IDLE: begin
            if (|acc) begin
              seen <= seen_nx;
              if (complete) begin
                st <= ST_DONE;
                o  <= 1'b1;
                if (fire_count != '1)
                  fire_count <= fire_count + COUNT_W'(1);
              end else begin
                st <= ST_COLLECT;
              end
            end
          end
          ST_COLLECT: begin
            if (complete) begin
              st   <= ST_DONE;
              seen <= seen_nx;
              o    <= 1'b1;
              if (fire_count != '1)
                fire_count <= fire_count + COUNT_W'(1);
            end else if (expire) begin
              st      <= ST_IDLE;
              seen    <= '0;
              timeout <= 1'b1;
            end else begin
              seen <= seen_nx;
            end
          end
          ST_DONE: begin
          end
          default: begin
            st   <= ST_IDLE;
            seen <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_abro_multi_event_fsm.sv
// Directed bench for abro_multi_event_fsm: four instances with
// different parameters share one stimulus stream.
module tb_abro_multi_event_fsm;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] ev_in;
  logic [3:0] ev_mask;
  logic       r_in;

  logic       o0, o1, o2, o3;
  logic [3:0] seen0, seen1, seen2, seen3;
  logic [1:0] st0, st1, st2, st3;
  logic       to0, to1, to2, to3;
  logic [7:0] fc0, fc1, fc2;
  logic [1:0] fc3;

  int pass = 0;
  int total = 0;

  always #5 clk = ~clk;

  abro_multi_event_fsm #(
    .N_EVENTS(4), .WINDOW_CYCLES(0), .OUT_MODE(0), .COUNT_W(8)
  ) u0 (
    .clk(clk), .reset(reset), .ev_in(ev_in), .ev_mask(ev_mask),
    .r_in(r_in), .o(o0), .seen(seen0), .state(st0),
    .timeout(to0), .fire_count(fc0)
  );

  abro_multi_event_fsm #(
    .N_EVENTS(4), .WINDOW_CYCLES(0), .OUT_MODE(1), .COUNT_W(8)
  ) u1 (
    .clk(clk), .reset(reset), .ev_in(ev_in), .ev_mask(ev_mask),
    .r_in(r_in), .o(o1), .seen(seen1), .state(st1),
    .timeout(to1), .fire_count(fc1)
  );

  abro_multi_event_fsm #(
    .N_EVENTS(4), .WINDOW_CYCLES(5), .OUT_MODE(0), .COUNT_W(8)
  ) u2 (
    .clk(clk), .reset(reset), .ev_in(ev_in), .ev_mask(ev_mask),
    .r_in(r_in), .o(o2), .seen(seen2), .state(st2),
    .timeout(to2), .fire_count(fc2)
  );

  abro_multi_event_fsm #(
    .N_EVENTS(4), .WINDOW_CYCLES(0), .OUT_MODE(0), .COUNT_W(2)
  ) u3 (
    .clk(clk), .reset(reset), .ev_in(ev_in), .ev_mask(ev_mask),
    .r_in(r_in), .o(o3), .seen(seen3), .state(st3),
    .timeout(to3), .fire_count(fc3)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset   = 1'b1;
    ev_in   = 4'b0000;
    ev_mask = 4'b1111;
    r_in    = 1'b0;
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (st0 !== 2'b00) $display("FAIL rst_state got=%b want=00", st0); else pass++;
    total++; if (seen0 !== 4'b0000) $display("FAIL rst_seen got=%b want=0000", seen0); else pass++;
    total++; if (o0 !== 1'b0 || o1 !== 1'b0) $display("FAIL rst_o got=%b%b want=00", o0, o1); else pass++;
    total++; if (to2 !== 1'b0) $display("FAIL rst_timeout got=%b want=0", to2); else pass++;
    total++; if (fc0 !== 8'd0) $display("FAIL rst_count got=%0d want=0", fc0); else pass++;
  endtask

  task automatic test_sequence();
    do_reset();
    ev_in = 4'b0001; step();
    total++; if (st0 !== 2'b01) $display("FAIL seq_state1 got=%b want=01", st0); else pass++;
    total++; if (seen0 !== 4'b0001) $display("FAIL seq_seen1 got=%b want=0001", seen0); else pass++;
    ev_in = 4'b0100; step();
    ev_in = 4'b0001; step();
    total++; if (seen0 !== 4'b0101) $display("FAIL seq_repeat got=%b want=0101", seen0); else pass++;
    ev_in = 4'b0010; step();
    total++; if (o0 !== 1'b0) $display("FAIL seq_early_o got=%b want=0", o0); else pass++;
    ev_in = 4'b1000; step();
    total++; if (o0 !== 1'b1) $display("FAIL seq_o got=%b want=1", o0); else pass++;
    total++; if (st0 !== 2'b10) $display("FAIL seq_done got=%b want=10", st0); else pass++;
    total++; if (fc0 !== 8'd1) $display("FAIL seq_count got=%0d want=1", fc0); else pass++;
    ev_in = 4'b0000; step();
    total++; if (o0 !== 1'b0) $display("FAIL seq_pulse got=%b want=0", o0); else pass++;
    for (int i = 0; i < 4; i++) begin
      ev_in = 4'b1111; step();
      total++; if (o0 !== 1'b0 || st0 !== 2'b10) $display("FAIL seq_hold got=%b/%b want=0/10", o0, st0); else pass++;
    end
    total++; if (seen0 !== 4'b1111 || fc0 !== 8'd1) $display("FAIL seq_frozen got=%b/%0d want=1111/1", seen0, fc0); else pass++;
  endtask

  task automatic test_simultaneous();
    do_reset();
    ev_in = 4'b1111; step();
    total++; if (st0 !== 2'b10 || o0 !== 1'b1) $display("FAIL sim_direct got=%b/%b want=10/1", st0, o0); else pass++;
    total++; if (o1 !== 1'b1) $display("FAIL sim_level_o got=%b want=1", o1); else pass++;
    ev_in = 4'b0000;
    for (int i = 0; i < 20; i++) begin
      step();
      total++; if (o1 !== 1'b1) $display("FAIL sim_level_hold cyc=%0d got=%b want=1", i, o1); else pass++;
    end
    total++; if (o0 !== 1'b0) $display("FAIL sim_pulse got=%b want=0", o0); else pass++;
    r_in = 1'b1; step(); r_in = 1'b0;
    total++; if (o1 !== 1'b0) $display("FAIL sim_restart_o got=%b want=0", o1); else pass++;
    total++; if (st1 !== 2'b00 || seen1 !== 4'b0000) $display("FAIL sim_restart got=%b/%b want=00/0000", st1, seen1); else pass++;
  endtask

  task automatic test_timeout();
    do_reset();
    ev_in = 4'b0001; step();
    ev_in = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      step();
      total++; if (st2 !== 2'b01 || to2 !== 1'b0) $display("FAIL to_window cyc=%0d got=%b/%b want=01/0", i, st2, to2); else pass++;
    end
    step();
    total++; if (to2 !== 1'b1) $display("FAIL to_pulse got=%b want=1", to2); else pass++;
    total++; if (st2 !== 2'b00 || seen2 !== 4'b0000) $display("FAIL to_clear got=%b/%b want=00/0000", st2, seen2); else pass++;
    step();
    total++; if (to2 !== 1'b0) $display("FAIL to_one_cycle got=%b want=0", to2); else pass++;
    do_reset();
    ev_in = 4'b0001; step();
    ev_in = 4'b0000;
    for (int i = 0; i < 4; i++) step();
    ev_in = 4'b1110; step();
    ev_in = 4'b0000;
    total++; if (o2 !== 1'b1 || to2 !== 1'b0) $display("FAIL to_complete_wins got=%b/%b want=1/0", o2, to2); else pass++;
    total++; if (st2 !== 2'b10) $display("FAIL to_complete_state got=%b want=10", st2); else pass++;
  endtask

  task automatic test_restart();
    do_reset();
    ev_in = 4'b0111; step();
    ev_in = 4'b1000; r_in = 1'b1; step();
    ev_in = 4'b0000; r_in = 1'b0;
    total++; if (o0 !== 1'b0 || st0 !== 2'b00) $display("FAIL rin_same got=%b/%b want=0/00", o0, st0); else pass++;
    total++; if (seen0 !== 4'b0000 || fc0 !== 8'd0) $display("FAIL rin_clear got=%b/%0d want=0000/0", seen0, fc0); else pass++;
    step();
    total++; if (o0 !== 1'b0) $display("FAIL rin_no_o got=%b want=0", o0); else pass++;
  endtask

  task automatic test_mask();
    logic [3:0] r;
    do_reset();
    ev_in = 4'b0111; step();
    ev_in = 4'b0000; step();
    total++; if (seen0 !== 4'b0111 || st0 !== 2'b01) $display("FAIL mask_pre got=%b/%b want=0111/01", seen0, st0); else pass++;
    ev_mask = 4'b0111; step();
    total++; if (st0 !== 2'b10 || o0 !== 1'b1) $display("FAIL mask_drop got=%b/%b want=10/1", st0, o0); else pass++;
    do_reset();
    ev_mask = 4'b0000;
    for (int i = 0; i < 8; i++) begin
      r = 4'($urandom);
      ev_in = r; step();
      total++; if (st0 !== 2'b00 || o0 !== 1'b0 || seen0 !== 4'b0000) $display("FAIL mask_zero ev=%b got=%b/%b/%b want=00/0/0000", r, st0, o0, seen0); else pass++;
    end
    ev_in = 4'b0000; ev_mask = 4'b1111;
  endtask

  task automatic test_saturate();
    logic [1:0] exp_fc [5];
    exp_fc = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
    do_reset();
    for (int i = 0; i < 5; i++) begin
      ev_in = 4'b1111; step();
      total++; if (fc3 !== exp_fc[i]) $display("FAIL sat_round%0d got=%0d want=%0d", i, fc3, exp_fc[i]); else pass++;
      ev_in = 4'b0000; r_in = 1'b1; step(); r_in = 1'b0;
    end
    ev_in = 4'b0001; step();
    total++; if (st3 !== 2'b01) $display("FAIL sat_collect got=%b want=01", st3); else pass++;
    reset = 1'b1; ev_in = 4'b0010; step(); reset = 1'b0; ev_in = 4'b0000;
    total++; if (st3 !== 2'b00 || seen3 !== 4'b0000 || o3 !== 1'b0) $display("FAIL sat_rst got=%b/%b/%b want=00/0000/0", st3, seen3, o3); else pass++;
    total++; if (fc3 !== 2'd0 || to3 !== 1'b0) $display("FAIL sat_rst_cnt got=%0d/%b want=0/0", fc3, to3); else pass++;
    total++; if (o1 !== 1'b0 || st1 !== 2'b00) $display("FAIL sat_rst_level got=%b/%b want=0/00", o1, st1); else pass++;
  endtask

  initial begin
    test_reset();
    test_sequence();
    test_simultaneous();
    test_timeout();
    test_restart();
    test_mask();
    test_saturate();
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end

endmodule
